// File: rtl/riscv_core_bp_pkg.sv
// Shared types, counter encodings and helpers for the branch predictor.
package riscv_core_bp_pkg;

  // The BTB entry is sized from these defaults; the top-level parameters are
  // expected to match them.
  localparam int unsigned BP_ADDRLEN     = 32;
  localparam int unsigned BP_BTB_ENTRIES = 16;
  localparam int unsigned BP_IDXW        = $clog2(BP_BTB_ENTRIES);
  localparam int unsigned BP_TAGW        = BP_ADDRLEN - BP_IDXW - 1;

  // 2-bit saturating direction counter states
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef struct packed {
    logic                  valid;
    logic [BP_TAGW-1:0]    tag;
    logic [BP_ADDRLEN-1:0] target;
    logic [1:0]            ctr;
  } btb_entry_t;

  // Move the counter one step toward the resolved direction, saturating at the ends
  function automatic logic [1:0] sat_ctr_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != CTR_ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/riscv_core_bp_btb.sv
// Direct-mapped BTB storage: two combinational read ports (fetch, update) and
// one synchronous write port. Reset clears every entry to invalid/weak-not-taken.
module riscv_core_bp_btb
  import riscv_core_bp_pkg::*;
#(
  parameter int unsigned ENTRIES = BP_BTB_ENTRIES,
  parameter int unsigned IDXW    = $clog2(ENTRIES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IDXW-1:0] fetch_idx,
  output btb_entry_t      fetch_entry,
  input  logic [IDXW-1:0] upd_idx,
  output btb_entry_t      upd_entry,
  input  logic            wr_en,
  input  logic [IDXW-1:0] wr_idx,
  input  btb_entry_t      wr_entry
);

  btb_entry_t mem [ENTRIES];

  // Reads return pre-write contents; a same-cycle write becomes visible next cycle
  assign fetch_entry = mem[fetch_idx];
  assign upd_entry   = mem[upd_idx];

  // Table storage; reset wins over a coincident write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        mem[IDXW'(i)] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
      end
    end else if (wr_en) begin
      mem[wr_idx] <= wr_entry;
    end
  end

endmodule

// File: rtl/riscv_core_branch_predictor.sv
// Branch predictor: combinational BTB lookup in IF, misprediction detection and
// redirect in EX, table training on the following clock edge.
// Optional build macro BP_PERF_CNT_EN adds branch / misprediction counters.
module riscv_core_branch_predictor
  import riscv_core_bp_pkg::*;
#(
  parameter int unsigned ADDRLEN     = BP_ADDRLEN,
  parameter int unsigned BTB_ENTRIES = BP_BTB_ENTRIES
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [ADDRLEN-1:0] i_bp_fetch_pc,
  output logic               o_bp_valid,
  output logic               o_bp_isTaken_BP,
  output logic [ADDRLEN-1:0] o_bp_predictedAddr,
  input  logic               i_bp_update_en,
  input  logic [ADDRLEN-1:0] i_bp_update_pc,
  input  logic               i_bp_update_pred_taken,
  input  logic [ADDRLEN-1:0] i_bp_update_pred_target,
  input  logic               i_bp_update_actual_taken,
  input  logic [ADDRLEN-1:0] i_bp_update_actual_target,
  input  logic [ADDRLEN-1:0] i_bp_update_PC_plus_offset,
  output logic               o_bp_misprediction,
  output logic [ADDRLEN-1:0] o_bp_recoveredAddr
`ifdef BP_PERF_CNT_EN
  ,
  output logic [31:0]        o_bp_branch_cnt,
  output logic [31:0]        o_bp_mispredict_cnt
`endif
);

  localparam int unsigned IDXW = $clog2(BTB_ENTRIES);
  localparam int unsigned TAGW = ADDRLEN - IDXW - 1;

  logic [IDXW-1:0] fetch_idx;
  logic [IDXW-1:0] upd_idx;
  logic [TAGW-1:0] fetch_tag;
  logic [TAGW-1:0] upd_tag;
  btb_entry_t      fetch_entry;
  btb_entry_t      upd_entry;
  btb_entry_t      wr_entry;
  logic            wr_en;
  logic            fetch_hit;
  logic            upd_hit;
  logic            unused_bits;

  // Bit 0 is always zero for halfword-aligned PCs and never indexes the table
  assign fetch_idx   = i_bp_fetch_pc[IDXW:1];
  assign fetch_tag   = i_bp_fetch_pc[ADDRLEN-1:IDXW+1];
  assign upd_idx     = i_bp_update_pc[IDXW:1];
  assign upd_tag     = i_bp_update_pc[ADDRLEN-1:IDXW+1];
  assign unused_bits = i_bp_fetch_pc[0] ^ i_bp_update_pc[0] ^ fetch_entry.ctr[0];

  riscv_core_bp_btb #(
    .ENTRIES (BTB_ENTRIES),
    .IDXW    (IDXW)
  ) u_btb (
    .clk         (i_clk),
    .rst         (i_rst),
    .fetch_idx   (fetch_idx),
    .fetch_entry (fetch_entry),
    .upd_idx     (upd_idx),
    .upd_entry   (upd_entry),
    .wr_en       (wr_en),
    .wr_idx      (upd_idx),
    .wr_entry    (wr_entry)
  );

  // IF-stage prediction; everything reads as zero on a miss
  always_comb begin
    fetch_hit          = fetch_entry.valid & (fetch_entry.tag == BP_TAGW'(fetch_tag));
    o_bp_valid         = fetch_hit;
    o_bp_isTaken_BP    = fetch_hit & fetch_entry.ctr[1];
    o_bp_predictedAddr = fetch_hit ? ADDRLEN'(fetch_entry.target) : '0;
  end

  // EX-stage resolution: wrong direction, or taken to a different target
  always_comb begin
    o_bp_misprediction = i_bp_update_en &
                         ((i_bp_update_pred_taken != i_bp_update_actual_taken) |
                          (i_bp_update_actual_taken &
                           (i_bp_update_pred_target != i_bp_update_actual_target)));
    o_bp_recoveredAddr = '0;
    if (o_bp_misprediction) begin
      o_bp_recoveredAddr = i_bp_update_actual_taken ? i_bp_update_actual_target
                                                    : i_bp_update_PC_plus_offset;
    end
  end

  // Training: hits move the counter (and refresh target if taken); taken misses allocate
  always_comb begin
    upd_hit  = upd_entry.valid & (upd_entry.tag == BP_TAGW'(upd_tag));
    wr_en    = 1'b0;
    wr_entry = upd_entry;
    if (i_bp_update_en) begin
      if (upd_hit) begin
        wr_en        = 1'b1;
        wr_entry.ctr = sat_ctr_update(upd_entry.ctr, i_bp_update_actual_taken);
        if (i_bp_update_actual_taken) begin
          wr_entry.target = BP_ADDRLEN'(i_bp_update_actual_target);
        end
      end else if (i_bp_update_actual_taken) begin
        wr_en    = 1'b1;
        wr_entry = '{valid:  1'b1,
                     tag:    BP_TAGW'(upd_tag),
                     target: BP_ADDRLEN'(i_bp_update_actual_target),
                     ctr:    CTR_WT};
      end
    end
  end

`ifdef BP_PERF_CNT_EN
  // Free-running resolved-branch and misprediction counters, wrapping at 2^32
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_bp_branch_cnt     <= '0;
      o_bp_mispredict_cnt <= '0;
    end else begin
      if (i_bp_update_en)     o_bp_branch_cnt     <= o_bp_branch_cnt + 32'd1;
      if (o_bp_misprediction) o_bp_mispredict_cnt <= o_bp_mispredict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_core_branch_predictor.sv
// Self-checking bench for riscv_core_branch_predictor (BTB_ENTRIES=16).
// Directed scenarios plus randomized traffic against a table-level reference model.
module tb_riscv_core_branch_predictor;

  localparam int AW = 32;
  localparam int N  = 16;

  logic          i_clk;
  logic          i_rst;
  logic [AW-1:0] i_bp_fetch_pc;
  logic          o_bp_valid;
  logic          o_bp_isTaken_BP;
  logic [AW-1:0] o_bp_predictedAddr;
  logic          i_bp_update_en;
  logic [AW-1:0] i_bp_update_pc;
  logic          i_bp_update_pred_taken;
  logic [AW-1:0] i_bp_update_pred_target;
  logic          i_bp_update_actual_taken;
  logic [AW-1:0] i_bp_update_actual_target;
  logic [AW-1:0] i_bp_update_PC_plus_offset;
  logic          o_bp_misprediction;
  logic [AW-1:0] o_bp_recoveredAddr;
`ifdef BP_PERF_CNT_EN
  logic [31:0]   o_bp_branch_cnt;
  logic [31:0]   o_bp_mispredict_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  riscv_core_branch_predictor #(.ADDRLEN(AW), .BTB_ENTRIES(N)) dut (
    .i_clk                      (i_clk),
    .i_rst                      (i_rst),
    .i_bp_fetch_pc              (i_bp_fetch_pc),
    .o_bp_valid                 (o_bp_valid),
    .o_bp_isTaken_BP            (o_bp_isTaken_BP),
    .o_bp_predictedAddr         (o_bp_predictedAddr),
    .i_bp_update_en             (i_bp_update_en),
    .i_bp_update_pc             (i_bp_update_pc),
    .i_bp_update_pred_taken     (i_bp_update_pred_taken),
    .i_bp_update_pred_target    (i_bp_update_pred_target),
    .i_bp_update_actual_taken   (i_bp_update_actual_taken),
    .i_bp_update_actual_target  (i_bp_update_actual_target),
    .i_bp_update_PC_plus_offset (i_bp_update_PC_plus_offset),
    .o_bp_misprediction         (o_bp_misprediction),
    .o_bp_recoveredAddr         (o_bp_recoveredAddr)
`ifdef BP_PERF_CNT_EN
    ,
    .o_bp_branch_cnt            (o_bp_branch_cnt),
    .o_bp_mispredict_cnt        (o_bp_mispredict_cnt)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- reference model: one record per BTB slot ----------------
  bit          m_valid [N];
  logic [31:0] m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];
  int unsigned m_branches;
  int unsigned m_mispreds;

  function automatic int slot_of(logic [31:0] pc);
    return int'((pc >> 1) % N);
  endfunction

  function automatic logic [31:0] tag_of(logic [31:0] pc);
    return pc >> 5;
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    return m_valid[slot_of(pc)] && (m_tag[slot_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit m_taken(logic [31:0] pc);
    return m_hit(pc) && (m_ctr[slot_of(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_addr(logic [31:0] pc);
    return m_hit(pc) ? m_tgt[slot_of(pc)] : 32'h0;
  endfunction

  function automatic bit exp_mis();
    if (!i_bp_update_en) return 1'b0;
    if (i_bp_update_pred_taken != i_bp_update_actual_taken) return 1'b1;
    return i_bp_update_actual_taken && (i_bp_update_pred_target != i_bp_update_actual_target);
  endfunction

  function automatic logic [31:0] exp_rec();
    if (!exp_mis()) return 32'h0;
    return i_bp_update_actual_taken ? i_bp_update_actual_target : i_bp_update_PC_plus_offset;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
    end
    m_branches = 0;
    m_mispreds = 0;
  endtask

  task automatic model_train(logic [31:0] pc, bit taken, logic [31:0] tgt);
    int s;
    s = slot_of(pc);
    if (m_hit(pc)) begin
      if (taken) begin
        m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
        m_tgt[s] = tgt;
      end else begin
        m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
      end
    end else if (taken) begin
      m_valid[s] = 1'b1; m_tag[s] = tag_of(pc); m_tgt[s] = tgt; m_ctr[s] = 2;
    end
  endtask

  // Advance one clock, letting the model absorb what the DUT sees at the edge
  task automatic cycle();
    bit mis;
    mis = exp_mis();
    @(posedge i_clk);
    if (i_rst) begin
      model_reset();
    end else if (i_bp_update_en) begin
      m_branches++;
      if (mis) m_mispreds++;
      model_train(i_bp_update_pc, i_bp_update_actual_taken, i_bp_update_actual_target);
    end
    #1;
  endtask

  task automatic set_update(bit en, logic [31:0] pc, bit pt, logic [31:0] ptg,
                            bit at, logic [31:0] atg, logic [31:0] ppo);
    i_bp_update_en             = en;
    i_bp_update_pc             = pc;
    i_bp_update_pred_taken     = pt;
    i_bp_update_pred_target    = ptg;
    i_bp_update_actual_taken   = at;
    i_bp_update_actual_target  = atg;
    i_bp_update_PC_plus_offset = ppo;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    i_rst = 1'b1;
    set_update(1'b0, 0, 0, 0, 0, 0, 0);
    i_bp_fetch_pc = 32'h100;
    cycle();
    cycle();
    i_rst = 1'b0;
    #1;
    tests_run++;
    if (o_bp_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_valid got=%b exp=0", o_bp_valid);
    end
    tests_run++;
    if (o_bp_isTaken_BP !== 1'b0) begin
      tests_failed++; $display("FAIL reset_taken got=%b exp=0", o_bp_isTaken_BP);
    end
    tests_run++;
    if (o_bp_predictedAddr !== 32'h0) begin
      tests_failed++; $display("FAIL reset_addr got=%h exp=0", o_bp_predictedAddr);
    end
    tests_run++;
    if (o_bp_misprediction !== 1'b0) begin
      tests_failed++; $display("FAIL reset_mis got=%b exp=0", o_bp_misprediction);
    end
`ifdef BP_PERF_CNT_EN
    tests_run++;
    if (o_bp_branch_cnt !== 32'd0 || o_bp_mispredict_cnt !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0", o_bp_branch_cnt, o_bp_mispredict_cnt);
    end
`endif
  endtask

  task automatic test_allocate();
    set_update(1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h80, 32'h104);
    i_bp_fetch_pc = 32'h100;
    #1;
    tests_run++;
    if (o_bp_misprediction !== 1'b1 || o_bp_recoveredAddr !== 32'h80) begin
      tests_failed++;
      $display("FAIL alloc_redirect got=%b/%h exp=1/00000080", o_bp_misprediction, o_bp_recoveredAddr);
    end
    tests_run++;
    if (o_bp_valid !== 1'b0) begin
      tests_failed++; $display("FAIL alloc_same_cycle_lookup got=%b exp=0", o_bp_valid);
    end
    cycle();
    set_update(1'b0, 0, 0, 0, 0, 0, 0);
    #1;
    tests_run++;
    if (o_bp_valid !== 1'b1 || o_bp_isTaken_BP !== 1'b1 || o_bp_predictedAddr !== 32'h80) begin
      tests_failed++;
      $display("FAIL alloc_lookup got=%b/%b/%h exp=1/1/00000080",
               o_bp_valid, o_bp_isTaken_BP, o_bp_predictedAddr);
    end
  endtask

  task automatic test_counter_decay();
    for (int k = 0; k < 2; k++) begin
      set_update(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0, 32'h104);
      #1;
      tests_run++;
      if (o_bp_misprediction !== 1'b1 || o_bp_recoveredAddr !== 32'h104) begin
        tests_failed++;
        $display("FAIL nt_redirect%0d got=%b/%h exp=1/00000104", k, o_bp_misprediction, o_bp_recoveredAddr);
      end
      cycle();
    end
    set_update(1'b0, 0, 0, 0, 0, 0, 0);
    i_bp_fetch_pc = 32'h100;
    #1;
    tests_run++;
    if (o_bp_valid !== 1'b1 || o_bp_isTaken_BP !== 1'b0 || o_bp_predictedAddr !== 32'h80) begin
      tests_failed++;
      $display("FAIL nt_lookup got=%b/%b/%h exp=1/0/00000080",
               o_bp_valid, o_bp_isTaken_BP, o_bp_predictedAddr);
    end
    // A further not-taken at strong-NT stays put and is predicted correctly
    set_update(1'b1, 32'h100, 1'b0, 32'h80, 1'b0, 32'h0, 32'h102);
    #1;
    tests_run++;
    if (o_bp_misprediction !== 1'b0 || o_bp_recoveredAddr !== 32'h0) begin
      tests_failed++;
      $display("FAIL nt_correct got=%b/%h exp=0/00000000", o_bp_misprediction, o_bp_recoveredAddr);
    end
    cycle();
  endtask

  task automatic test_replace();
    set_update(1'b1, 32'h120, 1'b0, 32'h0, 1'b1, 32'h200, 32'h124);
    cycle();
    set_update(1'b0, 0, 0, 0, 0, 0, 0);
    i_bp_fetch_pc = 32'h100;
    #1;
    tests_run++;
    if (o_bp_valid !== 1'b0 || o_bp_predictedAddr !== 32'h0) begin
      tests_failed++; $display("FAIL replace_old got=%b/%h exp=0/00000000", o_bp_valid, o_bp_predictedAddr);
    end
    i_bp_fetch_pc = 32'h120;
    #1;
    tests_run++;
    if (o_bp_valid !== 1'b1 || o_bp_isTaken_BP !== 1'b1 || o_bp_predictedAddr !== 32'h200) begin
      tests_failed++;
      $display("FAIL replace_new got=%b/%b/%h exp=1/1/00000200",
               o_bp_valid, o_bp_isTaken_BP, o_bp_predictedAddr);
    end
  endtask

  task automatic test_target_change();
    set_update(1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h80, 32'h104);
    cycle();
    set_update(1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h90, 32'h104);
    #1;
    tests_run++;
    if (o_bp_misprediction !== 1'b1 || o_bp_recoveredAddr !== 32'h90) begin
      tests_failed++;
      $display("FAIL tgt_redirect got=%b/%h exp=1/00000090", o_bp_misprediction, o_bp_recoveredAddr);
    end
    cycle();
    set_update(1'b0, 0, 0, 0, 0, 0, 0);
    i_bp_fetch_pc = 32'h100;
    #1;
    tests_run++;
    if (o_bp_valid !== 1'b1 || o_bp_isTaken_BP !== 1'b1 || o_bp_predictedAddr !== 32'h90) begin
      tests_failed++;
      $display("FAIL tgt_lookup got=%b/%b/%h exp=1/1/00000090",
               o_bp_valid, o_bp_isTaken_BP, o_bp_predictedAddr);
    end
    set_update(1'b1, 32'h100, 1'b1, 32'h90, 1'b1, 32'h90, 32'h104);
    #1;
    tests_run++;
    if (o_bp_misprediction !== 1'b0 || o_bp_recoveredAddr !== 32'h0) begin
      tests_failed++;
      $display("FAIL tgt_correct got=%b/%h exp=0/00000000", o_bp_misprediction, o_bp_recoveredAddr);
    end
    cycle();
  endtask

  // Aliasing-heavy random traffic: four tags over all 16 slots
  function automatic logic [31:0] rand_pc();
    return 32'h1000 | (32'($urandom_range(0, 3)) << 5) | (32'($urandom_range(0, N - 1)) << 1);
  endfunction

  task automatic test_random();
    logic [31:0] upc;
    bit pt, at;
    logic [31:0] ptg, atg;
    for (int n = 0; n < 600; n++) begin
      i_bp_fetch_pc = rand_pc();
      upc = rand_pc();
      if ($urandom_range(0, 4) != 0) begin
        pt  = m_taken(upc);
        ptg = m_addr(upc);
      end else begin
        pt  = 1'($urandom_range(0, 1));
        ptg = 32'h2000 | (32'($urandom_range(0, 3)) << 4);
      end
      at  = 1'($urandom_range(0, 1));
      atg = 32'h2000 | (32'($urandom_range(0, 3)) << 4);
      set_update(($urandom_range(0, 9) < 7), upc, pt, ptg, at, atg,
                 upc + (($urandom_range(0, 1) != 0) ? 32'd4 : 32'd2));
      i_rst = ($urandom_range(0, 99) == 0);
      #1;
      tests_run++;
      if (o_bp_valid !== m_hit(i_bp_fetch_pc) || o_bp_isTaken_BP !== m_taken(i_bp_fetch_pc) ||
          o_bp_predictedAddr !== m_addr(i_bp_fetch_pc)) begin
        tests_failed++;
        $display("FAIL rand_lookup n=%0d pc=%h got=%b/%b/%h exp=%b/%b/%h", n, i_bp_fetch_pc,
                 o_bp_valid, o_bp_isTaken_BP, o_bp_predictedAddr,
                 m_hit(i_bp_fetch_pc), m_taken(i_bp_fetch_pc), m_addr(i_bp_fetch_pc));
      end
      tests_run++;
      if (o_bp_misprediction !== exp_mis() || o_bp_recoveredAddr !== exp_rec()) begin
        tests_failed++;
        $display("FAIL rand_resolve n=%0d got=%b/%h exp=%b/%h", n,
                 o_bp_misprediction, o_bp_recoveredAddr, exp_mis(), exp_rec());
      end
`ifdef BP_PERF_CNT_EN
      tests_run++;
      if (o_bp_branch_cnt !== m_branches || o_bp_mispredict_cnt !== m_mispreds) begin
        tests_failed++;
        $display("FAIL rand_cnt n=%0d got=%0d/%0d exp=%0d/%0d", n,
                 o_bp_branch_cnt, o_bp_mispredict_cnt, m_branches, m_mispreds);
      end
`endif
      cycle();
      i_rst = 1'b0;
    end
  endtask

  task automatic test_reset_with_update();
    int bad;
    set_update(1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h80, 32'h104);
    cycle();
    i_rst = 1'b1;
    set_update(1'b1, 32'h140, 1'b0, 32'h0, 1'b1, 32'h300, 32'h144);
    cycle();
    i_rst = 1'b0;
    set_update(1'b0, 0, 0, 0, 0, 0, 0);
    bad = 0;
    for (int s = 0; s < N; s++) begin
      for (int t = 0; t < 4; t++) begin
        i_bp_fetch_pc = 32'h100 + 32'(t << 5) + 32'(s << 1);
        #1;
        if (o_bp_valid !== 1'b0 || o_bp_predictedAddr !== 32'h0) bad++;
      end
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++; $display("FAIL rst_update_lookups got=%0d valid lookups exp=0", bad);
    end
`ifdef BP_PERF_CNT_EN
    tests_run++;
    if (o_bp_branch_cnt !== 32'd0 || o_bp_mispredict_cnt !== 32'd0) begin
      tests_failed++;
      $display("FAIL rst_update_cnt got=%0d/%0d exp=0/0", o_bp_branch_cnt, o_bp_mispredict_cnt);
    end
`endif
  endtask

  initial begin
    i_rst = 1'b1;
    i_bp_fetch_pc = '0;
    set_update(1'b0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    test_reset();
    test_allocate();
    test_counter_decay();
    test_replace();
    test_target_change();
    test_random();
    test_reset_with_update();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
